// File: rtl/serial_adder_pkg.sv
// =====================================================================
// serial_adder_pkg : shared state encoding and default width
// Rev 1.0
// =====================================================================
`default_nettype none

package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/serial_adder_if.sv
// =====================================================================
// serial_adder_if : request/result handshake bundle of the serial adder
// Rev 1.0
// =====================================================================
`default_nettype none

interface serial_adder_if
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );

endinterface

`default_nettype wire

// File: rtl/Half_Adder.sv
// =====================================================================
// Half_Adder : single-bit half adder, the arithmetic cell of the datapath
// Rev 1.0
// =====================================================================
`default_nettype none

module Half_Adder (
  input  wire logic a_i,
  input  wire logic b_i,
  output logic      sum_o,
  output logic      carry_o
);

  assign sum_o   = a_i ^ b_i;
  assign carry_o = a_i & b_i;

endmodule

`default_nettype wire

// File: rtl/serial_adder_fa_cell.sv
// =====================================================================
// fa_cell : combinational full adder from two half adders
// Rev 1.0
// =====================================================================
`default_nettype none

module fa_cell (
  input  wire logic a_i,
  input  wire logic b_i,
  input  wire logic c_i,
  output logic      sum_o,
  output logic      cout_o
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  Half_Adder u_ha0 (
    .a_i     (a_i),
    .b_i     (b_i),
    .sum_o   (w_s0),
    .carry_o (w_c0)
  );

  Half_Adder u_ha1 (
    .a_i     (w_s0),
    .b_i     (c_i),
    .sum_o   (sum_o),
    .carry_o (w_c1)
  );

  // The two half-adder carries can never both be set, so OR is exact.
  assign cout_o = w_c0 | w_c1;

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
// =====================================================================
// serial_adder : bit-serial WIDTH-bit adder, LSB first, busy/done handshake
// Rev 1.0
// =====================================================================
`default_nettype none

module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  serial_adder_if.slave  bus
);

  localparam int              CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] op_a_q;
  logic [WIDTH-1:0] op_b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    cnt_q;

  logic             sum_bit_d;
  logic             carry_d;
  logic [WIDTH-1:0] sum_shift_d;

  fa_cell u_fa (
    .a_i    (op_a_q[0]),
    .b_i    (op_b_q[0]),
    .c_i    (carry_q),
    .sum_o  (sum_bit_d),
    .cout_o (carry_d)
  );

  // New bit enters at the MSB so that after WIDTH shifts bit 0 is the LSB.
  if (WIDTH == 1) begin : g_shift_w1
    assign sum_shift_d = sum_bit_d;
  end else begin : g_shift_wn
    assign sum_shift_d = {sum_bit_d, sum_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_a_q  <= bus.a;
            op_b_q  <= bus.b;
            carry_q <= bus.cin;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          sum_q   <= sum_shift_d;
          op_a_q  <= op_a_q >> 1;
          op_b_q  <= op_b_q >> 1;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST_CNT) begin
            cout_q  <= carry_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

`default_nettype wire

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder; the stage directly downstream of the single-bit Half_Adder, which it consumes as its arithmetic cell.
- Latches two operands on a start pulse and processes one bit per clock, LSB first.
- Each bit goes through a full-adder cell built from two Half_Adder instances, with the carry held in a flip-flop between bits.
- Delivers the sum and carry-out with busy/done handshake signalling to the next datapath stage.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  reset
start  input  1  request; sampled on rising edge; accepted only in IDLE or DONE
a  input  WIDTH  operand A; captured on the accepting edge
b  input  WIDTH  operand B; captured on the accepting edge
cin  input  1  carry-in; captured on the accepting edge
busy  output  1  high while a computation is in progress (state RUN)
done  output  1  one-cycle pulse: sum/cout valid
sum  output  WIDTH  result; stable from done until the next accepted start
cout  output  1  final carry-out; stable with sum

Interface fixed: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry FF and bit counter are cleared.
  - Release is synchronous to the next clk edge.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at edge E -> load opA=a, opB=b, carry=cin, cnt=0, clear sum -> RUN.
  - RUN: each edge:
    - bit = opA[0] ^ opB[0] ^ carry; carry = majority(opA[0], opB[0], carry).
    - bit is shifted into sum MSB (sum shifts right); opA/opB shift right; cnt++.
    - When cnt==WIDTH-1 on that edge -> DONE.
  - DONE: done=1 for exactly this one cycle.
    - start=1 on this edge is accepted (back-to-back) -> RUN with new operands.
    - Otherwise -> IDLE.
- Latency: start sampled at edge E -> RUN for edges E+1..E+WIDTH -> done high in the cycle after edge E+WIDTH (WIDTH+1 cycles start-to-done).
- busy=1 exactly while state==RUN. done and busy are never both 1.
- start while in RUN is ignored: no reload, no effect on the result.
- sum and cout are registered.
  - During RUN, sum holds intermediate shift contents and is not valid.
  - cout updates on the final RUN edge and holds until the next accepted start.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- Wrap-around: all-ones + 1 gives sum=0, cout=1.
- WIDTH=1: RUN lasts exactly one edge.
- Reset mid-RUN: aborts immediately to IDLE, outputs cleared, no done pulse.
- Counter width: clog2(WIDTH)+1 bits so that WIDTH=32 does not overflow.

Decomposition:
- Shared package serial_adder_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - Default width constant.
- One sub-module, fa_cell: a combinational full adder.
  - Built from two Half_Adder instances plus an OR of their carries.
  - Instantiated once in serial_adder.
  - Verified stand-alone exhaustively over all 8 input combinations.

Test Plan:
- WIDTH=8: a=8'h5A, b=8'h3C, cin=0, start pulse -> busy high 8 cycles, done pulse on cycle 9, sum=8'h96, cout=0.
- WIDTH=8: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Start held high during RUN with different operands (a=8'h00, b=8'h00) -> ignored; first result 8'h5A+8'h3C=8'h96 delivered unchanged at the original latency.
- Back-to-back: assert start in the DONE cycle with a=8'h10, b=8'h20 -> second done exactly 9 cycles after first done, sum=8'h30, cout=0.
- rst_n pulled low asynchronously (mid-cycle) at RUN bit 4 -> busy=0, sum=0, cout=0 immediately, no done pulse. A subsequent start with 8'h01+8'h01 gives sum=8'h02.
- WIDTH=1 instance: exhaustive 8 combinations of a, b, cin -> {cout,sum} equals the arithmetic sum, done 2 cycles after start each time.
